// File: rtl/mem_port_arbiter.sv
// Two-port arbiter in front of the cache-controller memory port.
// Locks the grant for a whole transaction and flags stalled downstream ops.
module mem_port_arbiter #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int PRIO_MODE = 0,
  parameter int TIMEOUT   = 1023
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [1:0]          req_r_en,
  input  logic [1:0]          req_w_en,
  input  logic [2*ADDR_W-1:0] req_addr,
  input  logic [2*DATA_W-1:0] req_wdata,
  output logic [DATA_W-1:0]   req_rdata,
  output logic [1:0]          req_ready,
  output logic [ADDR_W-1:0]   ds_addr,
  output logic [DATA_W-1:0]   ds_wdata,
  output logic                ds_en,
  output logic                ds_r_en,
  output logic                ds_w_en,
  input  logic [DATA_W-1:0]   ds_rdata,
  input  logic                ds_ready,
  output logic                grant_id,
  output logic                busy,
  output logic                timeout_err
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t         state;
  logic           rr_ptr;
  logic [CW-1:0]  cnt;
  logic [1:0]     req;
  logic           winner;
  logic           win_rd;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_wdata;

  assign req = req_r_en | req_w_en;

  // Pick the winner: sole requester, else round-robin pointer or port 0
  always_comb begin
    winner = 1'b0;
    unique case (req)
      2'b10:   winner = 1'b1;
      2'b11:   winner = (PRIO_MODE == 0) && rr_ptr;
      default: winner = 1'b0;
    endcase
  end

  assign win_rd    = req_r_en[winner];
  assign win_addr  = winner ? req_addr[2*ADDR_W-1:ADDR_W]
                            : req_addr[ADDR_W-1:0];
  assign win_wdata = winner ? req_wdata[2*DATA_W-1:DATA_W]
                            : req_wdata[DATA_W-1:0];

  // Transaction FSM with all outputs registered
  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      rr_ptr      <= 1'b0;
      cnt         <= '0;
      grant_id    <= 1'b0;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
      req_rdata   <= '0;
      req_ready   <= 2'b00;
      ds_addr     <= '0;
      ds_wdata    <= '0;
      ds_en       <= 1'b0;
      ds_r_en     <= 1'b0;
      ds_w_en     <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (|req) begin
            grant_id <= winner;
            ds_addr  <= win_addr;
            ds_wdata <= win_wdata;
            ds_en    <= 1'b1;
            ds_r_en  <= win_rd;
            ds_w_en  <= ~win_rd;
            busy     <= 1'b1;
            cnt      <= '0;
            state    <= BUSY;
          end
        end
        BUSY: begin
          if (ds_ready || cnt == CW'(TIMEOUT - 1)) begin
            ds_en     <= 1'b0;
            ds_r_en   <= 1'b0;
            ds_w_en   <= 1'b0;
            req_ready <= grant_id ? 2'b10 : 2'b01;
            state     <= DONE;
            if (ds_ready) begin
              req_rdata <= ds_rdata;
            end else begin
              req_rdata   <= '0;
              timeout_err <= 1'b1;
              cnt         <= CW'(TIMEOUT);
            end
          end else if (cnt != CW'(TIMEOUT)) begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          req_ready <= 2'b00;
          busy      <= 1'b0;
          if (PRIO_MODE == 0) begin
            rr_ptr <= ~grant_id;
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: round-robin instance and fixed-priority
// instance share stimulus; a scoreboard checks each completion.
module tb_mem_port_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]      req_r_en, req_w_en;
  logic [2*AW-1:0] req_addr;
  logic [2*DW-1:0] req_wdata;
  logic [DW-1:0]   ds_rdata;
  logic            ds_ready;

  logic [DW-1:0] a_rdata, b_rdata, m_rdata;
  logic [1:0]    a_ready, b_ready, m_ready;
  logic [AW-1:0] a_addr, b_addr, m_addr;
  logic [DW-1:0] a_wdata, b_wdata, m_wdata;
  logic a_en, a_r, a_w, a_gid, a_busy, a_to;
  logic b_en, b_r, b_w, b_gid, b_busy, b_to;
  logic m_en, m_r, m_w, m_gid, m_busy, m_to;
  bit   sel;
  bit   use_fixed;
  logic [DW-1:0] fixed_rd;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .PRIO_MODE(0), .TIMEOUT(TO)) u_rr (
    .clk(clk), .rst(rst), .req_r_en(req_r_en), .req_w_en(req_w_en),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_rdata(a_rdata),
    .req_ready(a_ready), .ds_addr(a_addr), .ds_wdata(a_wdata), .ds_en(a_en),
    .ds_r_en(a_r), .ds_w_en(a_w), .ds_rdata(ds_rdata), .ds_ready(ds_ready),
    .grant_id(a_gid), .busy(a_busy), .timeout_err(a_to));

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .PRIO_MODE(1), .TIMEOUT(TO)) u_fp (
    .clk(clk), .rst(rst), .req_r_en(req_r_en), .req_w_en(req_w_en),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_rdata(b_rdata),
    .req_ready(b_ready), .ds_addr(b_addr), .ds_wdata(b_wdata), .ds_en(b_en),
    .ds_r_en(b_r), .ds_w_en(b_w), .ds_rdata(ds_rdata), .ds_ready(ds_ready),
    .grant_id(b_gid), .busy(b_busy), .timeout_err(b_to));

  function automatic logic [DW-1:0] rfn(input logic [AW-1:0] a);
    return a ^ 32'h5A5A_0F0F;
  endfunction

  // Observed instance and the cache data model
  always_comb begin
    m_rdata = sel ? b_rdata : a_rdata;
    m_ready = sel ? b_ready : a_ready;
    m_addr  = sel ? b_addr  : a_addr;
    m_wdata = sel ? b_wdata : a_wdata;
    m_en    = sel ? b_en    : a_en;
    m_r     = sel ? b_r     : a_r;
    m_w     = sel ? b_w     : a_w;
    m_gid   = sel ? b_gid   : a_gid;
    m_busy  = sel ? b_busy  : a_busy;
    m_to    = sel ? b_to    : a_to;
    ds_rdata = use_fixed ? fixed_rd : rfn(m_addr);
  end

  typedef struct {
    logic [1:0]    r;
    logic [1:0]    w;
    logic [AW-1:0] a0, a1;
    logic [DW-1:0] d0, d1;
    int            miss;
    bit            first;
  } vec_t;

  typedef struct {
    bit            port;
    bit            rd;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
    int            lat;
    bit            to;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int passes = 0;
  int bcnt = 0;
  int miss = 0;
  logic [AW-1:0] f_addr;
  logic [DW-1:0] f_wdata;
  logic f_r, f_w;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // One cycle: sample at negedge, drive ds_ready, score completions
  task automatic step();
    exp_t e;
    @(negedge clk);
    if (m_en) begin
      if (bcnt == 0) begin
        f_addr = m_addr; f_wdata = m_wdata; f_r = m_r; f_w = m_w;
      end else begin
        chk("stable_addr", m_addr, f_addr);
        chk("stable_wdata", m_wdata, f_wdata);
        chk("stable_r_en", m_r, f_r);
        chk("stable_w_en", m_w, f_w);
      end
      ds_ready = (bcnt >= miss);
      bcnt++;
    end else begin
      ds_ready = 1'b0;
    end
    if (m_ready != 2'b00) begin
      if (sb.size() == 0) begin
        chk("unexpected_ready", m_ready, 2'b00);
      end else begin
        e = sb.pop_front();
        chk("ready_port", m_ready, e.port ? 2'b10 : 2'b01);
        chk("grant_id", m_gid, e.port);
        chk("ds_addr", f_addr, e.addr);
        chk("ds_r_en", f_r, e.rd);
        chk("ds_w_en", f_w, !e.rd);
        if (!e.rd) chk("ds_wdata", f_wdata, e.wdata);
        if (e.rd || e.to) chk("req_rdata", m_rdata, e.rdata);
        chk("latency", bcnt, e.lat);
        chk("timeout_err", m_to, e.to);
        chk("done_ds_en", m_en, 1'b0);
        chk("done_busy", m_busy, 1'b1);
        req_r_en[e.port] = 1'b0;
        req_w_en[e.port] = 1'b0;
      end
    end
    if (!m_en) bcnt = 0;
  endtask

  task automatic push(input vec_t v, input bit p);
    exp_t e;
    e.port  = p;
    e.rd    = v.r[p];
    e.addr  = p ? v.a1 : v.a0;
    e.wdata = p ? v.d1 : v.d0;
    e.to    = (v.miss >= TO);
    e.lat   = e.to ? TO : v.miss + 1;
    e.rdata = e.to ? '0 : (use_fixed ? fixed_rd : rfn(e.addr));
    sb.push_back(e);
  endtask

  task automatic drive(input vec_t v);
    logic [1:0] q;
    req_r_en  = v.r;
    req_w_en  = v.w;
    req_addr  = {v.a1, v.a0};
    req_wdata = {v.d1, v.d0};
    miss      = v.miss;
    q = v.r | v.w;
    if (q == 2'b11) begin
      push(v, v.first);
      push(v, !v.first);
    end else if (q[0]) begin
      push(v, 1'b0);
    end else if (q[1]) begin
      push(v, 1'b1);
    end
  endtask

  task automatic finish_round();
    int n;
    n = 0;
    while (sb.size() > 0 && n < 200) begin
      step();
      n++;
    end
    if (sb.size() > 0) begin
      chk("round_bound", sb.size(), 0);
      sb.delete();
    end
  endtask

  task automatic reset_pulse();
    req_r_en = 2'b00;
    req_w_en = 2'b00;
    rst = 1'b0;
    step();
    step();
    rst = 1'b1;
  endtask

  vec_t va[7];
  vec_t vb[3];
  vec_t vt;

  initial begin
    req_r_en = 2'b00; req_w_en = 2'b00;
    req_addr = '0; req_wdata = '0; ds_ready = 1'b0;
    sel = 1'b0; use_fixed = 1'b0; fixed_rd = '0;

    va[0] = '{2'b11, 2'b00, 32'h100, 32'h200, 32'h0, 32'h0, 0, 1'b0};
    va[1] = '{2'b00, 2'b11, 32'h104, 32'h204, 32'h1111_0000, 32'h2222_0000, 0, 1'b0};
    va[2] = '{2'b00, 2'b11, 32'h108, 32'h208, 32'h1111_0001, 32'h2222_0001, 0, 1'b0};
    va[3] = '{2'b01, 2'b00, 32'h10C, 32'h0, 32'h0, 32'h0, 0, 1'b0};
    va[4] = '{2'b01, 2'b11, 32'h110, 32'h210, 32'h3333_0000, 32'h4444_0000, 0, 1'b1};
    va[5] = '{2'b00, 2'b10, 32'h0, 32'h214, 32'h0, 32'h5555_0000, 5, 1'b0};
    va[6] = '{2'b11, 2'b00, 32'h118, 32'h218, 32'h0, 32'h0, 5, 1'b0};
    vb[0] = '{2'b01, 2'b00, 32'h300, 32'h0, 32'h0, 32'h0, 0, 1'b0};
    vb[1] = '{2'b11, 2'b00, 32'h304, 32'h404, 32'h0, 32'h0, 0, 1'b0};
    vb[2] = '{2'b00, 2'b11, 32'h308, 32'h408, 32'h6666_0000, 32'h7777_0000, 0, 1'b0};
    vt    = '{2'b10, 2'b00, 32'h0, 32'h500, 32'h0, 32'h0, 1000, 1'b0};

    drive(va[0]);
    for (int c = 0; c < 2; c++) begin
      step();
      chk("rst_ctrl", {m_ready, m_en, m_r, m_w, m_gid, m_busy, m_to}, 0);
      chk("rst_rdata", m_rdata, 0);
      chk("rst_addr", m_addr, 0);
      chk("rst_wdata", m_wdata, 0);
    end
    rst = 1'b1;
    finish_round();
    for (int i = 1; i < 7; i++) begin
      drive(va[i]);
      finish_round();
    end

    step();
    use_fixed = 1'b1;
    fixed_rd  = 32'hDEAD_BEEF;
    drive('{2'b01, 2'b00, 32'h40, 32'h0, 32'h0, 32'h0, 0, 1'b0});
    step();
    chk("hit_c1_r_en", {m_en, m_r, m_ready}, 4'b1100);
    chk("hit_c1_addr", m_addr, 32'h40);
    step();
    chk("hit_c2_ready", m_ready, 2'b01);
    chk("hit_c2_rdata", m_rdata, 32'hDEAD_BEEF);
    finish_round();
    use_fixed = 1'b0;

    reset_pulse();
    sel = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(vb[i]);
      finish_round();
    end

    reset_pulse();
    sel = 1'b0;
    drive(vt);
    finish_round();
    step();
    chk("timeout_sticky", m_to, 1'b1);

    req_w_en[0] = 1'b1;
    req_addr    = {32'h0, 32'h600};
    miss        = 1000;
    step();
    step();
    chk("midop_busy", {m_busy, m_en}, 2'b11);
    rst = 1'b0;
    step();
    req_w_en = 2'b00;
    chk("midop_rst_ctrl", {m_ready, m_en, m_w, m_busy, m_to}, 0);
    rst = 1'b1;
    for (int c = 0; c < 4; c++) step();
    chk("midop_idle", {m_busy, m_en, m_ready}, 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
